inst_enc_loader: RTL and testbench
==================================

Name: inst_enc_loader

Overview:
- Encoder counterpart of the instruction decoder: takes decoded fields (opcode, func3, func7, rs1, rs2, rd, immediate) and packs them into a 32-bit RV32I instruction word.
- Streams the encoded words into instruction memory through a registered valid/ready write port with an auto-incrementing word address.
- Used by the self-test/program-load path to fill imem before the core is released from reset.

Parameters:
- ADDR_W, 32, width of wr_addr.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH, 256, maximum number of words loadable before full; DEPTH >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: empties the output register, resets the word index and count.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- opcode  input  7  instruction opcode.
- func3  input  3  funct3.
- func7  input  7  funct7; for R-type and I-type shifts only.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- rd  input  5  destination register.
- imm  input  32  immediate, already sign-extended, byte-offset form; CSR address in imm[11:0].
- wr_en  output  1  imem write request (valid).
- wr_ready  input  1  imem accepts the write.
- wr_addr  output  ADDR_W  byte address of wr_data.
- wr_data  output  32  encoded instruction.
- count  output  $clog2(DEPTH+1)  words accepted since reset/clear.
- full  output  1  count == DEPTH.
- err  output  1  one-cycle pulse: accepted bundle had an unsupported opcode.

Behaviour:
- Reset (rst_n low, async): wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, full=0, err=0, internal word index=0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - in_ready = !full && (!wr_en || wr_ready), with no combinational path from in_valid.
  - Output transfer completes when wr_en && wr_ready.
- Latency: a bundle accepted on cycle N gives wr_en=1 with valid wr_data/wr_addr on cycle N+1.
- Back-pressure: while wr_en && !wr_ready, wr_en, wr_addr and wr_data hold stable.
- Accept and complete in the same cycle: the new word replaces the old one with no bubble, giving full throughput of 1 word/clk.
- Supported formats, selected by opcode; all bits not listed are 0:
  - R (0110011): {func7, rs2, rs1, func3, rd, op}.
  - I-ALU (0010011): {imm[11:0], rs1, func3, rd, op}. For func3 = 001 or 101, bits 31:25 come from func7 and bits 24:20 from imm[4:0].
  - Iload (0000011), JALR (1100111), CSR (1110011): {imm[11:0], rs1, func3, rd, op}.
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - LUI (0110111), AUIPC (0010111): {imm[31:12], rd, op}.
  - JAL (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Register fields not used by the format are forced to 0. This matches the decoder's zeroing rules, so decode(encode(x)) round-trips.
- Address and count:
  - wr_addr = BASE_ADDR + 4*index, where index is the value captured with the word.
  - index and count increment by 1 per legal accepted bundle.
  - index never wraps because full blocks acceptance at DEPTH.
- Illegal opcode:
  - The bundle is consumed (in_ready handshake completes).
  - err=1 on cycle N+1.
  - No wr_en, index and count unchanged.
  - A pending output word is unaffected.
- Full: after the DEPTH-th legal accept, full=1 and in_ready=0. The pending last word still drains normally. Only clear or reset reopens acceptance.
- clear (synchronous, priority over in_valid in the same cycle):
  - Next cycle: wr_en=0, index=0, count=0, full=0, err=0.
  - Any undrained word is discarded.
- Reset mid-transfer: all state returns to the reset values immediately. No partial write may be presented after rst_n rises.

Test Plan:
- Basic encodes, with wr_ready held 1 and one bundle per cycle:
  - add x3,x1,x2 -> 0x002081B3 @ 0x0.
  - addi x1,x0,5 -> 0x00500093 @ 0x4.
  - sw x2,8(x1) -> 0x0020A423 @ 0x8.
- Control-flow and upper-immediate encodes:
  - beq x1,x2,+8 -> 0x00208463.
  - lui x5,0x12345 (imm=0x12345000) -> 0x123452B7.
  - jal x1,+16 -> 0x010000EF.
  - Addresses increment by 4; every word appears 1 cycle after acceptance.
- Back-pressure: drop wr_ready for 3 cycles with a word pending -> wr_data/wr_addr stay stable and in_ready=0. On wr_ready=1, resume with no word lost or duplicated.
- Illegal opcode: opcode=7'h7F -> in_ready handshake completes, err pulses for 1 cycle, no wr_en, next legal word goes to the unchanged address.
- Full: DEPTH=4, send 5 legal bundles -> 4 writes at 0x0–0xC, full=1 after the 4th accept, 5th bundle held off (in_ready=0). Then clear -> count=0, next word written at 0x0.
- Reset: assert rst_n low while wr_en=1 and wr_ready=0 -> outputs go to reset values asynchronously. After release, the first word is written at BASE_ADDR.

Source files
------------

// File: rtl/inst_enc_loader.sv
// RV32I field-bundle encoder that streams packed instruction words into imem
// through a registered valid/ready write port with an auto-incrementing address.
module inst_enc_loader #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [6:0]                   opcode,
   input  logic [2:0]                   func3,
   input  logic [6:0]                   func7,
   input  logic [4:0]                   rs1,
   input  logic [4:0]                   rs2,
   input  logic [4:0]                   rd,
   input  logic [31:0]                  imm,
   output logic                         wr_en,
   input  logic                         wr_ready,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [31:0]                  wr_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         err
);

   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [CNT_W-1:0]  count_q,   count_d;
   logic              err_q,     err_d;

   logic [31:0]       enc_word;
   logic              enc_legal;
   logic              full_w;
   logic              accept;

   // Unused register fields fall out as zero because each format only
   // concatenates the fields it owns.
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (opcode)
         OP_R:     enc_word = {func7, rs2, rs1, func3, rd, opcode};
         OP_IALU: begin
            if (func3 == 3'b001 || func3 == 3'b101)
               enc_word = {func7, imm[4:0], rs1, func3, rd, opcode};
            else
               enc_word = {imm[11:0], rs1, func3, rd, opcode};
         end
         OP_LOAD, OP_JALR, OP_SYS:
                   enc_word = {imm[11:0], rs1, func3, rd, opcode};
         OP_STORE: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
         OP_BR:    enc_word = {imm[12], imm[10:5], rs2, rs1, func3,
                               imm[4:1], imm[11], opcode};
         OP_LUI, OP_AUIPC:
                   enc_word = {imm[31:12], rd, opcode};
         OP_JAL:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default:  enc_legal = 1'b0;
      endcase
   end

   assign full_w   = (count_q == CNT_W'(DEPTH));
   assign in_ready = !full_w && (!wr_en_q || wr_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_en_d   = wr_en_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      count_d   = count_q;
      err_d     = 1'b0;
      if (clear) begin
         wr_en_d   = 1'b0;
         wr_addr_d = BASE_ADDR;
         wr_data_d = '0;
         count_d   = '0;
      end else begin
         if (wr_en_q && wr_ready)
            wr_en_d = 1'b0;
         // A legal accept overrides the drain above, keeping 1 word/clk.
         if (accept) begin
            if (enc_legal) begin
               wr_en_d   = 1'b1;
               wr_data_d = enc_word;
               wr_addr_d = BASE_ADDR + (ADDR_W'(count_q) << 2);
               count_d   = count_q + CNT_W'(1);
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign count   = count_q;
   assign full    = full_w;
   assign err     = err_q;

endmodule

// File: tb/tb_inst_enc_loader.sv
// Directed self-checking bench for inst_enc_loader (DEPTH=4, BASE_ADDR=0).
module tb_inst_enc_loader;

   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, in_ready;
   logic [6:0]  opcode, func7;
   logic [2:0]  func3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        wr_en, wr_ready, full, err;
   logic [31:0] wr_addr, wr_data;
   logic [2:0]  count;

   int total  = 0;
   int passed = 0;

   inst_enc_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .func3(func3), .func7(func7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                        input logic [31:0] iv);
      opcode = op; func3 = f3; func7 = f7; rs1 = r1; rs2 = r2; rd = rdv; imm = iv;
      in_valid = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
      opcode = '0; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_wr_en", {31'b0, wr_en}, 32'h0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_count", {29'b0, count}, 32'h0);
      chk("rst_full_err", {30'b0, full, err}, 32'h0);
      #10 rst_n = 1'b1;
      tick();

      // basic encodes, one per cycle
      drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);        // add x3,x1,x2
      #1 chk("add_in_ready", {31'b0, in_ready}, 32'h1);
      tick();
      chk("add_wr_en", {31'b0, wr_en}, 32'h1);
      chk("add_data", wr_data, 32'h002081B3);
      chk("add_addr", wr_addr, 32'h0);
      drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);        // addi x1,x0,5
      tick();
      chk("addi_data", wr_data, 32'h00500093);
      chk("addi_addr", wr_addr, 32'h4);
      drive(7'b0100011, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8);        // sw x2,8(x1)
      tick();
      chk("sw_data", wr_data, 32'h0020A423);
      chk("sw_addr", wr_addr, 32'h8);
      in_valid = 1'b0;
      tick();
      chk("basic_drain_wr_en", {31'b0, wr_en}, 32'h0);
      chk("basic_count", {29'b0, count}, 32'h3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_count", {29'b0, count}, 32'h0);

      // control flow and upper immediates; junk in unused fields must not leak
      drive(7'b1100011, 3'b000, 7'h7F, 5'd1, 5'd2, 5'd31, 32'd8);       // beq x1,x2,+8
      tick();
      chk("beq_data", wr_data, 32'h00208463);
      chk("beq_addr", wr_addr, 32'h0);
      drive(7'b0110111, 3'b111, 7'h7F, 5'd9, 5'd3, 5'd5, 32'h12345000); // lui x5,0x12345
      tick();
      chk("lui_data", wr_data, 32'h123452B7);
      chk("lui_addr", wr_addr, 32'h4);
      drive(7'b1101111, 3'b101, 7'h55, 5'd7, 5'd6, 5'd1, 32'd16);       // jal x1,+16
      tick();
      chk("jal_data", wr_data, 32'h010000EF);
      chk("jal_addr", wr_addr, 32'h8);
      in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // back-pressure
      drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);
      tick();
      chk("bp_first_data", wr_data, 32'h00500093);
      wr_ready = 1'b0;
      drive(7'b0010011, 3'b101, 7'b0100000, 5'd2, 5'd0, 5'd1, 32'd3);  // srai x1,x2,3
      #1 chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_wr_en", {31'b0, wr_en}, 32'h1);
         chk("bp_hold_data", wr_data, 32'h00500093);
         chk("bp_hold_addr", wr_addr, 32'h0);
      end
      wr_ready = 1'b1;
      #1 chk("bp_in_ready_high", {31'b0, in_ready}, 32'h1);
      tick();
      chk("srai_data", wr_data, 32'h40315093);
      chk("srai_addr", wr_addr, 32'h4);
      in_valid = 1'b0;
      tick();
      chk("bp_count", {29'b0, count}, 32'h2);

      // illegal opcode
      drive(7'h7F, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);
      #1 chk("ill_in_ready", {31'b0, in_ready}, 32'h1);
      tick();
      chk("ill_err", {31'b0, err}, 32'h1);
      chk("ill_wr_en", {31'b0, wr_en}, 32'h0);
      chk("ill_count", {29'b0, count}, 32'h2);
      drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);
      tick();
      chk("ill_err_pulse", {31'b0, err}, 32'h0);
      chk("post_ill_data", wr_data, 32'h002081B3);
      chk("post_ill_addr", wr_addr, 32'h8);
      in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // full at DEPTH=4
      drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("full_seq_addr", wr_addr, 32'(4 * i));
         chk("full_seq_data", wr_data, (32'(i) << 20) | 32'h93);
         drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'(i + 1));
      end
      chk("full_flag", {31'b0, full}, 32'h1);
      chk("full_count", {29'b0, count}, 32'h4);
      #1 chk("full_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
      chk("full_drain_wr_en", {31'b0, wr_en}, 32'h0);
      chk("full_held_in_ready", {31'b0, in_ready}, 32'h0);
      chk("full_held_count", {29'b0, count}, 32'h4);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_count", {29'b0, count}, 32'h0);
      chk("clr_full", {31'b0, full}, 32'h0);
      #1 chk("clr_in_ready", {31'b0, in_ready}, 32'h1);
      tick();
      chk("clr_next_addr", wr_addr, 32'h0);
      chk("clr_next_data", wr_data, 32'h00400093);

      // async reset while a word is stalled
      drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);
      tick();
      wr_ready = 1'b0;
      in_valid = 1'b0;
      chk("pre_rst_wr_en", {31'b0, wr_en}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr_en", {31'b0, wr_en}, 32'h0);
      chk("arst_wr_addr", wr_addr, 32'h0);
      chk("arst_wr_data", wr_data, 32'h0);
      chk("arst_count", {29'b0, count}, 32'h0);
      #3 rst_n = 1'b1;
      wr_ready = 1'b1;
      tick();
      chk("post_rst_wr_en", {31'b0, wr_en}, 32'h0);
      drive(7'b1100011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8);
      tick();
      chk("post_rst_addr", wr_addr, 32'h0);
      chk("post_rst_data", wr_data, 32'h00208463);
      chk("post_rst_count", {29'b0, count}, 32'h1);
      in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
